// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default baud divisor and receiver FSM states.
// Pure declarations; no latency.
// No flow control involved.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Flop chain that brings the asynchronous rx line into the clk domain.
// Latency: STAGES cycles.
// No backpressure; resets to 1 so an idle line is seen during and after reset.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register read through uart_sel & rd.
// Latency: rx_valid_o rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge.
// No backpressure: an unread byte is overwritten and flagged on overrun_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      uart_sel,
    input  logic                      rd,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      rx_valid_o,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_e            state;
    uart_rx_state_e            state_nxt;
    logic                      rx_s;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      counting;
    logic                      bit_smp;
    logic                      load;
    logic                      rd_evt;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (cnt == HALF_END) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (cnt == BIT_END && bit_idx == LAST_BIT) state_nxt = STOP;
            STOP:    if (cnt == BIT_END) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state != IDLE);
        counting = (state == START) || (state == DATA) || (state == STOP);
        bit_smp  = (state == DATA) && (cnt == BIT_END);
        load     = (state == STOP) && (cnt == BIT_END);
    end

    // Only an actual unread byte can be consumed; reads of an empty register are ignored.
    assign rd_evt = uart_sel & rd & rx_valid_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_nxt != state || bit_smp) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + 1'b1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (bit_smp) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (bit_smp) begin
                shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o      <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else if (load) begin
            data_o     <= shreg;
            rx_valid_o <= 1'b1;
            // A simultaneous read retires the old byte, so flags describe only the new one.
            if (rd_evt) begin
                frame_err_o <= ~rx_s;
                overrun_o   <= 1'b0;
            end else begin
                frame_err_o <= frame_err_o | ~rx_s;
                overrun_o   <= overrun_o | rx_valid_o;
            end
        end else if (rd_evt) begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end
    end

endmodule
